// File: rtl/rs_add_pkg.sv
// Shared reservation-station definitions: default widths/depth and the entry field layout.
// Every reservation station imports this so entries look the same across all of them.
package rs_add_pkg;

    localparam int RS_DATA_WIDTH = 32;
    localparam int RS_TAG_WIDTH  = 4;
    localparam int RS_DEPTH      = 4;

    // An operand is either present (valid, data meaningful) or waiting on tag.
    typedef struct packed {
        logic                     valid;
        logic [RS_TAG_WIDTH-1:0]  tag;
        logic [RS_DATA_WIDTH-1:0] data;
    } rs_opnd_t;

    typedef struct packed {
        logic                    busy;
        logic [RS_TAG_WIDTH-1:0] dest;
        rs_opnd_t                src0;
        rs_opnd_t                src1;
    } rs_entry_t;

    function automatic int rs_occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rs_add_find_first.sv
// Lowest-set-bit finder: one-hot of the lowest request bit plus a found flag.
module rs_add_find_first #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] req_i,
    output logic [WIDTH-1:0] onehot_o,
    output logic             found_o
);

    // Two's-complement trick isolates the lowest set bit.
    assign onehot_o = req_i & (~req_i + WIDTH'(1));
    assign found_o  = |req_i;

endmodule

// File: rtl/rs_add.sv
// Reservation station for the adder: holds dispatched adds until both operands are
// present, snoops the CDB for wakeup, and issues the lowest-index ready entry.
module rs_add
    import rs_add_pkg::*;
#(
    parameter int DATA_WIDTH = RS_DATA_WIDTH,
    parameter int TAG_WIDTH  = RS_TAG_WIDTH,
    parameter int DEPTH      = RS_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    disp_valid,
    output logic                    disp_ready,
    input  logic [TAG_WIDTH-1:0]    disp_tag,
    input  logic                    disp_rdy0,
    input  logic [TAG_WIDTH-1:0]    disp_src0_tag,
    input  logic [DATA_WIDTH-1:0]   disp_src0_data,
    input  logic                    disp_rdy1,
    input  logic [TAG_WIDTH-1:0]    disp_src1_tag,
    input  logic [DATA_WIDTH-1:0]   disp_src1_data,
    input  logic                    cdb_valid,
    input  logic [TAG_WIDTH-1:0]    cdb_tag,
    input  logic [DATA_WIDTH-1:0]   cdb_data,
    input  logic                    fu_idle,
    output logic                    fu_ce,
    output logic [DATA_WIDTH-1:0]   fu_data_0,
    output logic [DATA_WIDTH-1:0]   fu_data_1,
    output logic [TAG_WIDTH-1:0]    issued_tag,
    output logic [$clog2(DEPTH):0]  occupancy
);

    localparam int OCC_W = rs_occ_width(DEPTH);

    // Same field order as rs_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic                  valid;
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } opnd_t;

    typedef struct packed {
        logic                 busy;
        logic [TAG_WIDTH-1:0] dest;
        opnd_t                src0;
        opnd_t                src1;
    } entry_t;

    entry_t               entries_q [DEPTH];
    entry_t               entries_d [DEPTH];
    logic [TAG_WIDTH-1:0] issued_tag_q;
    logic [TAG_WIDTH-1:0] issued_tag_d;

    logic [DEPTH-1:0] busy_vec;
    logic [DEPTH-1:0] ready_vec;
    logic [DEPTH-1:0] free_oh;
    logic [DEPTH-1:0] sel_oh;
    logic             free_found;
    logic             sel_found;
    logic             disp_accept;

    function automatic opnd_t snoop(input opnd_t o, input logic cv,
                                    input logic [TAG_WIDTH-1:0] ct,
                                    input logic [DATA_WIDTH-1:0] cd);
        opnd_t r;
        r = o;
        if (!o.valid && cv && (o.tag == ct)) begin
            r.valid = 1'b1;
            r.data  = cd;
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            busy_vec[i]  = entries_q[i].busy;
            ready_vec[i] = entries_q[i].busy & entries_q[i].src0.valid & entries_q[i].src1.valid;
        end
    end

    assign occupancy   = OCC_W'($countones(busy_vec));
    assign disp_ready  = occupancy < OCC_W'(DEPTH);
    assign disp_accept = disp_valid & disp_ready & free_found;
    assign fu_ce       = fu_idle & sel_found;
    assign issued_tag  = issued_tag_q;

    rs_add_find_first #(.WIDTH(DEPTH)) u_alloc (
        .req_i    (~busy_vec),
        .onehot_o (free_oh),
        .found_o  (free_found)
    );

    rs_add_find_first #(.WIDTH(DEPTH)) u_select (
        .req_i    (ready_vec),
        .onehot_o (sel_oh),
        .found_o  (sel_found)
    );

    // The allocator only ever sees non-busy entries, so it cannot pick the issuing one.
    always_comb begin
        issued_tag_d = issued_tag_q;
        fu_data_0    = '0;
        fu_data_1    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = entries_q[i];
            if (entries_q[i].busy) begin
                entries_d[i].src0 = snoop(entries_q[i].src0, cdb_valid, cdb_tag, cdb_data);
                entries_d[i].src1 = snoop(entries_q[i].src1, cdb_valid, cdb_tag, cdb_data);
            end
            if (fu_ce && sel_oh[i]) begin
                entries_d[i].busy = 1'b0;
                issued_tag_d      = entries_q[i].dest;
                fu_data_0         = fu_data_0 | entries_q[i].src0.data;
                fu_data_1         = fu_data_1 | entries_q[i].src1.data;
            end
            if (disp_accept && free_oh[i]) begin
                entries_d[i].busy = 1'b1;
                entries_d[i].dest = disp_tag;
                entries_d[i].src0 = snoop('{valid: disp_rdy0, tag: disp_src0_tag, data: disp_src0_data},
                                          cdb_valid, cdb_tag, cdb_data);
                entries_d[i].src1 = snoop('{valid: disp_rdy1, tag: disp_src1_tag, data: disp_src1_data},
                                          cdb_valid, cdb_tag, cdb_data);
            end
        end
    end

    // NOTE: the whole entry array is reset, not just busy, so a reset leaves no stale
    // operand state that a later partial write could expose.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
            issued_tag_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
            issued_tag_q <= issued_tag_d;
        end
    end

endmodule

// File: tb/tb_rs_add.sv
// Scoreboard bench for rs_add: a slot-level reference model predicts each issue,
// and a free-running monitor compares whatever the adder port presents.
module tb_rs_add;

    localparam int DW    = 32;
    localparam int TW    = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          disp_valid = 1'b0;
    logic          disp_ready;
    logic [TW-1:0] disp_tag = '0;
    logic          disp_rdy0 = 1'b0;
    logic [TW-1:0] disp_src0_tag = '0;
    logic [DW-1:0] disp_src0_data = '0;
    logic          disp_rdy1 = 1'b0;
    logic [TW-1:0] disp_src1_tag = '0;
    logic [DW-1:0] disp_src1_data = '0;
    logic          cdb_valid = 1'b0;
    logic [TW-1:0] cdb_tag = '0;
    logic [DW-1:0] cdb_data = '0;
    logic          fu_idle = 1'b0;
    logic          fu_ce;
    logic [DW-1:0] fu_data_0;
    logic [DW-1:0] fu_data_1;
    logic [TW-1:0] issued_tag;
    logic [2:0]    occupancy;

    always #5 clk = ~clk;

    rs_add #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .disp_valid     (disp_valid),
        .disp_ready     (disp_ready),
        .disp_tag       (disp_tag),
        .disp_rdy0      (disp_rdy0),
        .disp_src0_tag  (disp_src0_tag),
        .disp_src0_data (disp_src0_data),
        .disp_rdy1      (disp_rdy1),
        .disp_src1_tag  (disp_src1_tag),
        .disp_src1_data (disp_src1_data),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_data       (cdb_data),
        .fu_idle        (fu_idle),
        .fu_ce          (fu_ce),
        .fu_data_0      (fu_data_0),
        .fu_data_1      (fu_data_1),
        .issued_tag     (issued_tag),
        .occupancy      (occupancy)
    );

    typedef struct {
        logic [TW-1:0] tag;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
    } issue_t;

    issue_t exp_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;

    // Reference model: one record per slot, operands indexed 0/1.
    bit            m_busy [DEPTH];
    bit            m_val  [DEPTH][2];
    logic [TW-1:0] m_tag  [DEPTH][2];
    logic [DW-1:0] m_dat  [DEPTH][2];
    logic [TW-1:0] m_dest [DEPTH];
    bit            exp_ce;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) if (m_busy[i]) c++;
        return c;
    endfunction

    function automatic int m_ready_sel();
        for (int i = 0; i < DEPTH; i++)
            if (m_busy[i] && m_val[i][0] && m_val[i][1]) return i;
        return -1;
    endfunction

    // Applies the inputs that were visible at this rising edge to the model.
    task automatic model_update();
        int sel;
        int slot;
        logic          rdy [2];
        logic [TW-1:0] stg [2];
        logic [DW-1:0] sdt [2];
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
            return;
        end
        sel  = fu_idle ? m_ready_sel() : -1;
        slot = -1;
        if (disp_valid && m_count() < DEPTH)
            for (int i = DEPTH - 1; i >= 0; i--) if (!m_busy[i]) slot = i;
        if (cdb_valid)
            for (int i = 0; i < DEPTH; i++)
                for (int k = 0; k < 2; k++)
                    if (m_busy[i] && !m_val[i][k] && m_tag[i][k] == cdb_tag) begin
                        m_val[i][k] = 1;
                        m_dat[i][k] = cdb_data;
                    end
        if (sel >= 0) m_busy[sel] = 0;
        if (slot >= 0) begin
            rdy[0] = disp_rdy0; stg[0] = disp_src0_tag; sdt[0] = disp_src0_data;
            rdy[1] = disp_rdy1; stg[1] = disp_src1_tag; sdt[1] = disp_src1_data;
            m_busy[slot] = 1;
            m_dest[slot] = disp_tag;
            for (int k = 0; k < 2; k++) begin
                m_tag[slot][k] = stg[k];
                if (rdy[k]) begin
                    m_val[slot][k] = 1; m_dat[slot][k] = sdt[k];
                end else if (cdb_valid && stg[k] == cdb_tag) begin
                    m_val[slot][k] = 1; m_dat[slot][k] = cdb_data;
                end else begin
                    m_val[slot][k] = 0; m_dat[slot][k] = sdt[k];
                end
            end
        end
    endtask

    task automatic model_eval();
        int sel;
        issue_t e;
        exp_ce = 0;
        sel = (rst && fu_idle) ? m_ready_sel() : -1;
        if (sel >= 0) begin
            e.tag = m_dest[sel]; e.d0 = m_dat[sel][0]; e.d1 = m_dat[sel][1];
            exp_q.push_back(e);
            exp_ce = 1;
        end
    endtask

    task automatic drive(input bit dv, input logic [TW-1:0] tag,
                         input bit r0, input logic [TW-1:0] t0, input logic [DW-1:0] d0,
                         input bit r1, input logic [TW-1:0] t1, input logic [DW-1:0] d1,
                         input bit cv, input logic [TW-1:0] ct, input logic [DW-1:0] cd,
                         input bit idle);
        @(posedge clk);
        model_update();
        #1;
        disp_valid = dv; disp_tag = tag;
        disp_rdy0 = r0; disp_src0_tag = t0; disp_src0_data = d0;
        disp_rdy1 = r1; disp_src1_tag = t1; disp_src1_data = d1;
        cdb_valid = cv; cdb_tag = ct; cdb_data = cd;
        fu_idle = idle;
        model_eval();
        #3;
        check("fu_ce", 64'(fu_ce), 64'(exp_ce));
        check("occupancy", 64'(occupancy), 64'(m_count()));
        check("disp_ready", 64'(disp_ready), 64'(m_count() < DEPTH));
    endtask

    task automatic nop(input bit idle);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, idle);
    endtask

    // Monitor: pops one expectation per issue the DUT presents.
    initial begin
        issue_t e;
        forever begin
            @(negedge clk);
            if (fu_ce === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_issue: unexpected issue, got data0=%0h data1=%0h, expected none",
                             fu_data_0, fu_data_1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data0", 64'(fu_data_0), 64'(e.d0));
                    check("sb_data1", 64'(fu_data_1), 64'(e.d1));
                    @(posedge clk);
                    #1;
                    check("sb_issued_tag", 64'(issued_tag), 64'(e.tag));
                end
            end else begin
                check("sb_idle_data", {fu_data_0, fu_data_1}, 64'(0));
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_occupancy", 64'(occupancy), 64'(0));
        check("rst_disp_ready", 64'(disp_ready), 64'(1));
        check("rst_fu_ce", 64'(fu_ce), 64'(0));
        check("rst_issued_tag", 64'(issued_tag), 64'(0));
        #2 rst = 1'b1;

        // Both operands present: issue on the following cycle.
        drive(1, 3, 1, 0, 5, 1, 0, 7, 0, 0, 0, 1);
        nop(1);
        check("t027_ce", 64'(fu_ce), 64'(1));
        check("t027_d0", 64'(fu_data_0), 64'(5));
        check("t027_d1", 64'(fu_data_1), 64'(7));
        nop(1);
        check("t027_tag", 64'(issued_tag), 64'(3));

        // Wakeup by CDB broadcast.
        drive(1, 2, 1, 0, 32'h11, 0, 9, 0, 0, 0, 0, 1);
        nop(1);
        check("t028_wait", 64'(fu_ce), 64'(0));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h10, 1);
        check("t028_bcast_cycle", 64'(fu_ce), 64'(0));
        nop(1);
        check("t028_ce", 64'(fu_ce), 64'(1));
        check("t028_d1", 64'(fu_data_1), 64'(32'h10));
        nop(1);

        // Same-cycle bypass at dispatch.
        drive(1, 6, 0, 4, 0, 1, 0, 32'h22, 1, 4, 32'h44, 1);
        nop(1);
        check("t029_ce", 64'(fu_ce), 64'(1));
        check("t029_d0", 64'(fu_data_0), 64'(32'h44));
        nop(1);

        // Fill with the adder busy, then a held fifth dispatch.
        for (int i = 0; i < 4; i++)
            drive(1, TW'(8 + i), 1, 0, DW'(32'h100 + i), 1, 0, DW'(32'h200 + i), 0, 0, 0, 0);
        drive(1, 12, 1, 0, 32'h999, 1, 0, 32'h998, 0, 0, 0, 0);
        check("t030_ready", 64'(disp_ready), 64'(0));
        check("t030_occ", 64'(occupancy), 64'(4));
        drive(1, 12, 1, 0, 32'h999, 1, 0, 32'h998, 0, 0, 0, 0);
        check("t030_held", 64'(occupancy), 64'(4));

        // Full with issue and dispatch together: issue wins, dispatch waits.
        drive(1, 12, 1, 0, 32'h999, 1, 0, 32'h998, 0, 0, 0, 1);
        check("t031_ce", 64'(fu_ce), 64'(1));
        check("t031_entry0", 64'(fu_data_0), 64'(32'h100));
        check("t031_ready", 64'(disp_ready), 64'(0));
        nop(0);
        check("t031_occ", 64'(occupancy), 64'(3));
        check("t031_tag", 64'(issued_tag), 64'(8));
        repeat (6) nop(1);

        // Asynchronous reset with three entries, one already ready.
        drive(1, 1, 1, 0, 32'hA, 1, 0, 32'hB, 0, 0, 0, 0);
        drive(1, 5, 0, 15, 0, 1, 0, 32'hC, 0, 0, 0, 0);
        drive(1, 7, 1, 0, 32'hD, 0, 14, 0, 0, 0, 0, 0);
        nop(0);
        check("t032_pre_occ", 64'(occupancy), 64'(3));
        @(posedge clk);
        model_update();
        #2 rst = 1'b0;
        #1;
        check("t032_occ", 64'(occupancy), 64'(0));
        check("t032_ce", 64'(fu_ce), 64'(0));
        check("t032_ready", 64'(disp_ready), 64'(1));
        check("t032_tag", 64'(issued_tag), 64'(0));
        fu_idle = 1'b1;
        @(posedge clk);
        model_update();
        #2 rst = 1'b1;
        nop(1);
        check("t032_no_issue", 64'(fu_ce), 64'(0));
        nop(1);

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++)
            drive($urandom_range(0, 1) == 1, TW'($urandom),
                  $urandom_range(0, 2) != 0, TW'($urandom), $urandom,
                  $urandom_range(0, 2) != 0, TW'($urandom), $urandom,
                  $urandom_range(0, 1) == 1, TW'($urandom), $urandom,
                  $urandom_range(0, 9) < 7);
        for (int n = 0; n < 16; n++)
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, TW'(n), $urandom, 1);
        repeat (4) nop(1);

        repeat (2) @(negedge clk);
        #1;
        check("sb_drained", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rs_add.md
RS_ADD -- requirements
Module: RS_ADD

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 32, operand width; TAG_WIDTH, default 4, ROB/rename tag width; DEPTH, default 4, entry count.
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have disp_valid in 1 and disp_ready out 1: dispatch handshake; transfer occurs when both are high at a rising edge.
REQ-005 SHALL have disp_tag in TAG_WIDTH: destination tag of the dispatched add.
REQ-006 SHALL have disp_rdy0/disp_rdy1 in 1, disp_src0_tag/disp_src1_tag in TAG_WIDTH, disp_src0_data/disp_src1_data in DATA_WIDTH: operand present flag, producer tag if absent, value if present.
REQ-007 SHALL have cdb_valid in 1, cdb_tag in TAG_WIDTH, cdb_data in DATA_WIDTH: result broadcast bus.
REQ-008 SHALL have fu_idle in 1, from the adder's idle.
REQ-009 SHALL have fu_ce out 1, fu_data_0/fu_data_1 out DATA_WIDTH: issue strobe and operands to the adder.
REQ-010 SHALL have issued_tag out TAG_WIDTH: tag of the most recently issued entry; occupancy out $clog2(DEPTH)+1: busy entry count.

Function
REQ-011 Each entry SHALL hold busy, dest tag, and per operand a valid bit, tag, and data.
REQ-012 disp_ready SHALL equal (occupancy < DEPTH), from current-cycle state only; an issue in the same cycle does not raise it.
REQ-013 Accepted dispatch SHALL write the lowest-index non-busy entry.
REQ-014 On dispatch, an operand with rdy=0 whose tag equals cdb_tag while cdb_valid=1 SHALL be captured as valid with cdb_data (same-cycle bypass).
REQ-015 Each cycle with cdb_valid=1, every busy entry's invalid operand whose tag matches cdb_tag SHALL become valid with cdb_data; all matching entries capture.
REQ-016 An entry SHALL be ready when busy and both operands valid; readiness is evaluated on registered state, so the earliest issue is the cycle after dispatch or wakeup.
REQ-017 fu_ce SHALL be combinational: high iff fu_idle=1 and at least one entry is ready; it then selects the lowest-index ready entry.
REQ-018 fu_data_0/fu_data_1 SHALL carry the selected entry's operand 0/1 while fu_ce=1, and zero otherwise.
REQ-019 On a rising edge with fu_ce=1, the selected entry SHALL clear busy and issued_tag SHALL load its dest tag; at most one issue per cycle.
REQ-020 Dispatch and issue in the same cycle SHALL both take effect; occupancy changes by +1, -1 or 0 accordingly.
REQ-021 A dispatch SHALL never allocate the entry being issued in the same cycle.
REQ-022 CDB tags matching no waiting operand SHALL be ignored; tags are compared in full width, with no wrap-around handling.

Reset
REQ-023 While rst=0, all entries SHALL be non-busy, occupancy=0, issued_tag=0, fu_ce=0, fu_data_0/1=0 and disp_ready=1, independent of clk.
REQ-024 Reset mid-operation SHALL discard all entries, including ready ones; no issue occurs on the edge at which reset releases.

Structure
REQ-025 DATA_WIDTH, TAG_WIDTH, DEPTH defaults and the entry field layout SHALL live in the shared package used by all reservation stations.
REQ-026 One sub-module, RS_FIND_FIRST (DEPTH-bit lowest-set-bit one-hot plus found flag), SHALL be instantiated twice: free-entry allocation and ready-entry selection.

Verification
REQ-027 Dispatch tag=3, src0=5 and src1=7 (both ready), fu_idle=1 -> next cycle fu_ce=1, fu_data_0=5, fu_data_1=7; issued_tag=3 after that edge.
REQ-028 Dispatch tag=2 with src1 waiting on tag 9, then cdb_valid with tag 9 and data 0x10 -> fu_ce on the cycle after the broadcast, with fu_data_1=0x10.
REQ-029 Dispatch with src0 tag 4 waiting while cdb carries tag 4 in the same cycle -> the entry is ready next cycle; no stall.
REQ-030 Four dispatches with fu_idle=0 -> disp_ready=0, occupancy=4; a fifth disp_valid is not accepted; raising fu_idle issues entry 0 first.
REQ-031 Full RS, fu_idle=1 with issue and disp_valid in the same cycle -> the issue occurs, the dispatch is held, and occupancy goes 4 -> 3.
REQ-032 Pull rst low with 3 busy entries between clock edges -> occupancy=0 and fu_ce=0 immediately; no issue after release.
